// File: rtl/alu_ctrl_pkg.sv
// Shared constants, opcodes and FSM state type for the ALU scheduler.
// Imported by alu_rr_scheduler and rr_arbiter.
package alu_ctrl_pkg;

  localparam int DATA_W = 4;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] OP_NOP = 3'b000;
  localparam logic [OP_W-1:0] OP_ADD = 3'b001;
  localparam logic [OP_W-1:0] OP_SUB = 3'b010;
  localparam logic [OP_W-1:0] OP_AND = 3'b011;
  localparam logic [OP_W-1:0] OP_OR  = 3'b100;
  localparam logic [OP_W-1:0] OP_XOR = 3'b101;
  localparam logic [OP_W-1:0] OP_SHL = 3'b110;
  localparam logic [OP_W-1:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_e;

endpackage

// File: rtl/alu_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches req_i from last_i+1 with wrap.
// Ports: req_i, last_i in; gnt_o (one-hot or zero), idx_o (winner index) out.
module rr_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  last_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  idx_o
);

  logic found;
  int   j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = (int'(last_i) + k) % N_REQ;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one 4-bit ALU among N_REQ requesters: rr grant, register, execute, respond.
// Ports: req_* (valid/ready cmd), rsp_* (valid/ready result), alu_* (to/from ALU).
// Macro ALU_OPCHK_EN: opcode 000 bypasses the ALU and raises rsp_err.
module alu_rr_scheduler
  import alu_ctrl_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [4*N_REQ-1:0] req_a,
  input  logic [4*N_REQ-1:0] req_b,
  input  logic [3*N_REQ-1:0] req_opcode,
  input  logic [N_REQ-1:0]   req_in_sel,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [3:0]         rsp_out,
  output logic               rsp_carry,
  output logic [ID_W-1:0]    rsp_id,
  output logic               rsp_err,
  output logic [3:0]         alu_a,
  output logic [3:0]         alu_b,
  output logic [2:0]         alu_opcode,
  output logic               alu_in_sel,
  input  logic [3:0]         alu_out,
  input  logic               alu_carry
);

  state_e state_q, state_d;

  logic [ID_W-1:0]   last_q, last_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              sel_q, sel_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              carry_q, carry_d;
  logic              valid_q, valid_d;
`ifdef ALU_OPCHK_EN
  logic              err_q, err_d;
`endif

  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_idx;
  int               sel_base;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req_i  (req_valid),
    .last_i (last_q),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    sel_d     = sel_q;
    out_d     = out_q;
    carry_d   = carry_q;
    valid_d   = valid_q;
`ifdef ALU_OPCHK_EN
    err_d     = err_q;
`endif
    req_ready = '0;
    sel_base  = int'(gnt_idx);

    unique case (state_q)
      IDLE: begin
        req_ready = gnt;
        if (|gnt) begin
          a_d     = req_a[sel_base*DATA_W +: DATA_W];
          b_d     = req_b[sel_base*DATA_W +: DATA_W];
          op_d    = req_opcode[sel_base*OP_W +: OP_W];
          sel_d   = req_in_sel[sel_base];
          id_d    = gnt_idx;
          last_d  = gnt_idx;
          state_d = EXEC;
        end
      end
      EXEC: begin
        out_d   = alu_out;
        carry_d = alu_carry;
`ifdef ALU_OPCHK_EN
        err_d   = 1'b0;
        if (op_q == OP_NOP) begin
          out_d   = '0;
          carry_d = 1'b0;
          err_d   = 1'b1;
        end
`endif
        valid_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (rsp_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= ID_W'(N_REQ - 1);
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      sel_q   <= 1'b0;
      out_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
`ifdef ALU_OPCHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
`ifdef ALU_OPCHK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign rsp_valid  = valid_q;
  assign rsp_out    = out_q;
  assign rsp_carry  = carry_q;
  assign rsp_id     = id_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_opcode = op_q;
  assign alu_in_sel = sel_q;
`ifdef ALU_OPCHK_EN
  assign rsp_err    = err_q;
`else
  assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Randomized scoreboard bench for alu_rr_scheduler with 3 requesters.
// Includes a behavioural 4-bit ALU driving alu_out/alu_carry.
module tb_alu_rr_scheduler;

  localparam int N  = 3;
  localparam int IW = 2;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [3:0]    out;
    logic          c;
    logic          err;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [4*N-1:0] req_a;
  logic [4*N-1:0] req_b;
  logic [3*N-1:0] req_opcode;
  logic [N-1:0]   req_in_sel;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [3:0]     rsp_out;
  logic           rsp_carry;
  logic [IW-1:0]  rsp_id;
  logic           rsp_err;
  logic [3:0]     alu_a;
  logic [3:0]     alu_b;
  logic [2:0]     alu_opcode;
  logic           alu_in_sel;
  logic [3:0]     alu_out;
  logic           alu_carry;

  logic [3:0] pa [N];
  logic [3:0] pb [N];
  logic [2:0] po [N];
  logic       ps [N];

  always #5 clk = ~clk;

  alu_rr_scheduler #(.N_REQ(N), .ID_W(IW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_opcode (req_opcode),
    .req_in_sel (req_in_sel),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_out    (rsp_out),
    .rsp_carry  (rsp_carry),
    .rsp_id     (rsp_id),
    .rsp_err    (rsp_err),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_in_sel (alu_in_sel),
    .alu_out    (alu_out),
    .alu_carry  (alu_carry)
  );

  // Team ALU behaviour: {carry, result}
  function automatic logic [4:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op, input logic s);
    logic [3:0] src;
    src = s ? b : a;
    case (op)
      3'd1: return {1'b0, a} + {1'b0, b};
      3'd2: return {1'b0, a} - {1'b0, b};
      3'd3: return {1'b0, a & b};
      3'd4: return {1'b0, a | b};
      3'd5: return {1'b0, a ^ b};
      3'd6: return {src[3], src[2:0], 1'b0};
      3'd7: return {src[0], 1'b0, src[3:1]};
      default: return 5'd0;
    endcase
  endfunction

  function automatic exp_t exp_of(input int id, input logic [3:0] a, input logic [3:0] b,
                                  input logic [2:0] op, input logic s);
    exp_t e;
    logic [4:0] r;
    r     = ref_alu(a, b, op, s);
    e.id  = IW'(id);
    e.out = r[3:0];
    e.c   = r[4];
    e.err = 1'b0;
`ifdef ALU_OPCHK_EN
    if (op == 3'd0) begin
      e.out = 4'd0;
      e.c   = 1'b0;
      e.err = 1'b1;
    end
`endif
    return e;
  endfunction

  always_comb {alu_carry, alu_out} = ref_alu(alu_a, alu_b, alu_opcode, alu_in_sel);

  always_comb begin
    req_a      = '0;
    req_b      = '0;
    req_opcode = '0;
    req_in_sel = '0;
    for (int i = 0; i < N; i++) begin
      req_a[4*i +: 4]      = pa[i];
      req_b[4*i +: 4]      = pb[i];
      req_opcode[3*i +: 3] = po[i];
      req_in_sel[i]        = ps[i];
    end
  end

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  exp_t         q[$];
  int           acc_id[$];
  int           acc_cy[$];
  bit           busy    = 1'b0;
  int           last    = N - 1;
  int           acc_cyc = 0;
  int           cyc     = 0;
  logic [N-1:0] gmask   = '0;
  int           win;
  int           jj;

  // Monitor: predicts grants and checks responses each cycle
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      busy  = 1'b0;
      last  = N - 1;
      gmask = '0;
    end else begin
      for (int i = 0; i < N; i++)
        if (req_ready[i] && req_valid[i]) begin
          acc_id.push_back(i);
          acc_cy.push_back(cyc);
        end
      gmask = '0;
      if (busy) begin
        chk("req_ready_busy", 32'(req_ready), 32'd0);
        chk("rsp_valid_timing", 32'(rsp_valid), 32'(cyc >= acc_cyc + 2));
        if (rsp_valid) begin
          if (q.size() == 0) begin
            chk("rsp_unexpected", 32'd1, 32'd0);
          end else begin
            chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
            chk("rsp_out", 32'(rsp_out), 32'(q[0].out));
            chk("rsp_carry", 32'(rsp_carry), 32'(q[0].c));
            chk("rsp_err", 32'(rsp_err), 32'(q[0].err));
          end
          if (rsp_ready) begin
            if (q.size() > 0) void'(q.pop_front());
            busy = 1'b0;
          end
        end
      end else begin
        chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
        win = -1;
        for (int k = 1; k <= N; k++) begin
          jj = (last + k) % N;
          if (win < 0 && req_valid[jj]) win = jj;
        end
        if (win >= 0) gmask[win] = 1'b1;
        chk("req_ready_grant", 32'(req_ready), 32'(gmask));
        if (win >= 0) begin
          q.push_back(exp_of(win, pa[win], pb[win], po[win], ps[win]));
          last    = win;
          busy    = 1'b1;
          acc_cyc = cyc;
        end
      end
    end
  end

  task automatic tick(output logic [N-1:0] took);
    @(posedge clk);
    took = gmask;
    #1;
    req_valid = req_valid & ~took;
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] op, input logic s);
    pa[i] = a;
    pb[i] = b;
    po[i] = op;
    ps[i] = s;
    req_valid[i] = 1'b1;
  endtask

  task automatic set_rand(input int i);
    set_req(i, 4'($urandom), 4'($urandom), 3'($urandom), 1'($urandom));
  endtask

  logic [N-1:0] took;
  bit           done;

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      pa[i] = '0; pb[i] = '0; po[i] = '0; ps[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_out", 32'(rsp_out), 32'd0);
    chk("rst_rsp_carry", 32'(rsp_carry), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_op", 32'(alu_opcode), 32'd0);
    chk("rst_alu_sel", 32'(alu_in_sel), 32'd0);
    rst_n = 1'b1;

    // single requesters, including 4-bit add wrap with carry
    rsp_ready = 1'b1;
    set_req(0, 4'h3, 4'h5, 3'b001, 1'b0);
    repeat (6) tick(took);
    set_req(1, 4'hF, 4'h1, 3'b001, 1'b0);
    repeat (6) tick(took);

    // two requesters continuously valid: alternate, one accept per 3 cycles
    acc_id.delete();
    acc_cy.delete();
    set_rand(0);
    set_rand(1);
    repeat (14) begin
      tick(took);
      if (!req_valid[0]) set_rand(0);
      if (!req_valid[1]) set_rand(1);
    end
    req_valid = '0;
    repeat (4) tick(took);
    chk("rr_accept_count_ge4", 32'(acc_id.size() >= 4), 32'd1);
    if (acc_id.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("rr_order", 32'(acc_id[i]), 32'(i % 2));
        if (i > 0) chk("rr_interval", 32'(acc_cy[i] - acc_cy[i-1]), 32'd3);
      end
    end

    // response stall with a competing request pending
    rsp_ready = 1'b0;
    set_req(0, 4'h9, 4'h4, 3'b010, 1'b0);
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      tick(took);
      if (rsp_valid) done = 1'b1;
    end
    chk("stall_rsp_seen", 32'(done), 32'd1);
    set_req(2, 4'h6, 4'h3, 3'b110, 1'b1);
    repeat (5) tick(took);
    rsp_ready = 1'b1;
    repeat (8) tick(took);

    // reset asserted while in EXEC
    set_req(1, 4'hA, 4'hC, 3'b010, 1'b1);
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      tick(took);
      if (took[1]) done = 1'b1;
    end
    chk("exec_reached", 32'(done), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_alu_a", 32'(alu_a), 32'd0);
    chk("midrst_alu_b", 32'(alu_b), 32'd0);
    chk("midrst_alu_op", 32'(alu_opcode), 32'd0);
    chk("midrst_alu_sel", 32'(alu_in_sel), 32'd0);
    set_req(0, 4'h2, 4'h2, 3'b101, 1'b0);
    set_req(1, 4'h8, 4'h1, 3'b111, 1'b0);
    repeat (2) tick(took);
    acc_id.delete();
    acc_cy.delete();
    rst_n = 1'b1;
    repeat (8) tick(took);
    chk("post_rst_first_grant", 32'((acc_id.size() > 0) ? acc_id[0] : 99), 32'd0);

    // opcode 000 on the wrap-around requester
    set_req(2, 4'h7, 4'h2, 3'b000, 1'b0);
    repeat (6) tick(took);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      tick(took);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(2) == 0) set_rand(i);
        end else if ($urandom_range(15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(3) != 0);
    end

    req_valid = '0;
    rsp_ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick(took);
      if (!busy && q.size() == 0) done = 1'b1;
    end
    chk("drain_empty", 32'(done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
